// File: rtl/wdma_pkg.sv
`default_nettype none
// ==== wdma_pkg : shared types and sizing helpers for the weight DMA ==== rev 1.0 ====

package wdma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } wdma_state_e;

  localparam int WDMA_DRAIN_W = 3;

  // Bank 0 is the conv bank, the FC banks follow it.
  function automatic int wdma_nb(input int num_fc);
    return num_fc + 1;
  endfunction

  function automatic int wdma_sel_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/weight_dma_nch_if.sv
`default_nettype none
// ==== weight_dma_nch_if : control, source-read and bank-write bus of the weight DMA ==== rev 1.0 ====
// WDMA_CHECKSUM_EN adds o_checksum to the bus.

interface weight_dma_nch_if #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int LW = 16,
  parameter int NB = 5
);

  logic          i_dma_start;
  logic          i_abort;
  logic [AW-1:0] i_src_base;
  logic [LW-1:0] i_conv_len;
  logic [LW-1:0] i_fc_len;
  logic          o_src_rd;
  logic [AW-1:0] o_src_addr;
  logic [DW-1:0] i_src_data;
  logic          o_wr_en;
  logic [NB-1:0] o_wr_bank;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_busy;
  logic          o_done;
`ifdef WDMA_CHECKSUM_EN
  logic [DW-1:0] o_checksum;

  modport slave (
    input  i_dma_start, i_abort, i_src_base, i_conv_len, i_fc_len, i_src_data,
    output o_src_rd, o_src_addr, o_wr_en, o_wr_bank, o_wr_addr, o_wr_data,
    output o_busy, o_done, o_checksum
  );

  modport master (
    output i_dma_start, i_abort, i_src_base, i_conv_len, i_fc_len, i_src_data,
    input  o_src_rd, o_src_addr, o_wr_en, o_wr_bank, o_wr_addr, o_wr_data,
    input  o_busy, o_done, o_checksum
  );
`else
  modport slave (
    input  i_dma_start, i_abort, i_src_base, i_conv_len, i_fc_len, i_src_data,
    output o_src_rd, o_src_addr, o_wr_en, o_wr_bank, o_wr_addr, o_wr_data,
    output o_busy, o_done
  );

  modport master (
    output i_dma_start, i_abort, i_src_base, i_conv_len, i_fc_len, i_src_data,
    input  o_src_rd, o_src_addr, o_wr_en, o_wr_bank, o_wr_addr, o_wr_data,
    input  o_busy, o_done
  );
`endif

endinterface

`default_nettype wire

// File: rtl/wdma_tag_pipe.sv
`default_nettype none
// ==== wdma_tag_pipe : DEPTH-stage valid+tag delay line matching source read latency ==== rev 1.0 ====

module wdma_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int TW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          in_vld_i,
  input  logic [TW-1:0] in_tag_i,
  output logic          out_vld_o,
  output logic [TW-1:0] out_tag_o
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic          vld_q;
    logic [TW-1:0] tag_q;
    logic          w_vld_in;
    logic [TW-1:0] w_tag_in;

    if (i == 0) begin : g_head
      assign w_vld_in = in_vld_i;
      assign w_tag_in = in_tag_i;
    end else begin : g_link
      assign w_vld_in = g_stage[i-1].vld_q;
      assign w_tag_in = g_stage[i-1].tag_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= 1'b0;
        tag_q <= '0;
      end else if (flush_i) begin
        vld_q <= 1'b0;
        tag_q <= '0;
      end else begin
        vld_q <= w_vld_in;
        tag_q <= w_tag_in;
      end
    end
  end

  assign out_vld_o = g_stage[DEPTH-1].vld_q;
  assign out_tag_o = g_stage[DEPTH-1].tag_q;

endmodule

`default_nettype wire

// File: rtl/weight_dma_nch.sv
`default_nettype none
// ==== weight_dma_nch : streams a weight image into one conv bank and NUM_FC FC banks ==== rev 1.0 ====
// Optional WDMA_CHECKSUM_EN adds a modulo-2^DW running sum of all written words.

module weight_dma_nch
  import wdma_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int LW     = 16,
  parameter int NUM_FC = 4,
  parameter int RD_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  weight_dma_nch_if.slave bus
);

  localparam int NB = wdma_nb(NUM_FC);
  localparam int SW = wdma_sel_w(NB);
  localparam int TW = NB + AW;

  typedef struct packed {
    logic [NB-1:0] bank;
    logic [AW-1:0] addr;
  } tag_t;

  wdma_state_e             state_q;
  logic [LW-1:0]           conv_len_q;
  logic [LW-1:0]           fc_len_q;
  logic [LW-1:0]           widx_q;
  logic [SW-1:0]           seg_q;
  logic [WDMA_DRAIN_W-1:0] drain_q;
  logic                    src_rd_q;
  logic [AW-1:0]           src_addr_q;
  logic                    busy_q;
  logic                    done_q;

  logic [LW-1:0] w_seg_len;
  logic          w_seg_last;
  logic          w_next_seg;
  logic          w_start;
  logic          w_flush;
  logic          w_wr_vld;
  tag_t          w_rd_tag;
  tag_t          w_wr_tag;
  logic [DW-1:0] w_wr_data;

  assign w_seg_len  = (seg_q == '0) ? conv_len_q : fc_len_q;
  assign w_seg_last = (widx_q == w_seg_len - LW'(1));
  // All FC segments share one length, so the only possible successor is seg_q+1.
  assign w_next_seg = (fc_len_q != '0) && (seg_q < SW'(NUM_FC));
  assign w_start    = (state_q == IDLE) && bus.i_dma_start && !bus.i_abort;
  assign w_flush    = bus.i_abort && (state_q != IDLE);

  assign w_rd_tag.bank = NB'(1) << seg_q;
  assign w_rd_tag.addr = AW'(widx_q);

  wdma_tag_pipe #(
    .DEPTH (RD_LAT),
    .TW    (TW)
  ) u_tag_pipe (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .flush_i   (w_flush),
    .in_vld_i  (src_rd_q),
    .in_tag_i  (w_rd_tag),
    .out_vld_o (w_wr_vld),
    .out_tag_o (w_wr_tag)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      conv_len_q <= '0;
      fc_len_q   <= '0;
      widx_q     <= '0;
      seg_q      <= '0;
      drain_q    <= '0;
      src_rd_q   <= 1'b0;
      src_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // The first read goes out on the start edge itself.
          if (w_start) begin
            conv_len_q <= bus.i_conv_len;
            fc_len_q   <= bus.i_fc_len;
            widx_q     <= '0;
            src_addr_q <= bus.i_src_base;
            seg_q      <= (bus.i_conv_len != '0) ? SW'(0) : SW'(1);
            if ((bus.i_conv_len != '0) || (bus.i_fc_len != '0)) begin
              state_q  <= ISSUE;
              busy_q   <= 1'b1;
              src_rd_q <= 1'b1;
              done_q   <= 1'b0;
            end else begin
              done_q   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.i_abort) begin
            state_q  <= IDLE;
            src_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
          end else if (!w_seg_last) begin
            widx_q     <= widx_q + LW'(1);
            src_addr_q <= src_addr_q + AW'(1);
          end else if (w_next_seg) begin
            seg_q      <= seg_q + SW'(1);
            widx_q     <= '0;
            src_addr_q <= src_addr_q + AW'(1);
          end else begin
            state_q  <= DRAIN;
            src_rd_q <= 1'b0;
            drain_q  <= WDMA_DRAIN_W'(RD_LAT - 1);
          end
        end
        DRAIN: begin
          if (bus.i_abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (drain_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - WDMA_DRAIN_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w_wr_data      = bus.i_src_data;
  assign bus.o_src_rd   = src_rd_q;
  assign bus.o_src_addr = src_addr_q;
  assign bus.o_wr_en    = w_wr_vld;
  assign bus.o_wr_bank  = w_wr_vld ? w_wr_tag.bank : '0;
  assign bus.o_wr_addr  = w_wr_vld ? w_wr_tag.addr : '0;
  assign bus.o_wr_data  = w_wr_data;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;

`ifdef WDMA_CHECKSUM_EN
  logic [DW-1:0] csum_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      csum_q <= '0;
    end else if (w_start) begin
      csum_q <= '0;
    end else if (w_wr_vld) begin
      csum_q <= csum_q + w_wr_data;
    end
  end

  assign bus.o_checksum = csum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_weight_dma_nch.sv
`default_nettype none
// ==== tb_weight_dma_nch : directed bench, one DUT with RD_LAT=1 and one with RD_LAT=3 ==== rev 1.0 ====

module tb_weight_dma_nch;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int LW = 16;
  localparam int NUM_FC = 4;
  localparam int NB = NUM_FC + 1;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;

  always #5 clk = ~clk;

  weight_dma_nch_if #(.DW(DW), .AW(AW), .LW(LW), .NB(NB)) bus_a ();
  weight_dma_nch_if #(.DW(DW), .AW(AW), .LW(LW), .NB(NB)) bus_b ();

  weight_dma_nch #(.DW(DW), .AW(AW), .LW(LW), .NUM_FC(NUM_FC), .RD_LAT(1)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_a_n),
    .bus     (bus_a.slave)
  );

  weight_dma_nch #(.DW(DW), .AW(AW), .LW(LW), .NUM_FC(NUM_FC), .RD_LAT(3)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_b_n),
    .bus     (bus_b.slave)
  );

  // Source SRAM models: read data equals the address, delayed by the read latency.
  logic [AW-1:0] sa_q;
  logic [AW-1:0] sb_q [3];

  always @(posedge clk) begin
    sa_q    <= bus_a.o_src_addr;
    sb_q[0] <= bus_b.o_src_addr;
    sb_q[1] <= sb_q[0];
    sb_q[2] <= sb_q[1];
  end

  assign bus_a.i_src_data = sa_q;
  assign bus_b.i_src_data = sb_q[2];

  logic [NB-1:0] wbank [2][64];
  logic [AW-1:0] waddr [2][64];
  logic [DW-1:0] wdata [2][64];
  logic [AW-1:0] raddr [2][64];
  int wn [2];
  int rn [2];

  always @(negedge clk) begin
    if (bus_a.o_wr_en) begin
      if (wn[0] < 64) begin
        wbank[0][wn[0]] = bus_a.o_wr_bank;
        waddr[0][wn[0]] = bus_a.o_wr_addr;
        wdata[0][wn[0]] = bus_a.o_wr_data;
      end
      wn[0] = wn[0] + 1;
    end
    if (bus_a.o_src_rd) begin
      if (rn[0] < 64) raddr[0][rn[0]] = bus_a.o_src_addr;
      rn[0] = rn[0] + 1;
    end
    if (bus_b.o_wr_en) begin
      if (wn[1] < 64) begin
        wbank[1][wn[1]] = bus_b.o_wr_bank;
        waddr[1][wn[1]] = bus_b.o_wr_addr;
        wdata[1][wn[1]] = bus_b.o_wr_data;
      end
      wn[1] = wn[1] + 1;
    end
    if (bus_b.o_src_rd) begin
      if (rn[1] < 64) raddr[1][rn[1]] = bus_b.o_src_addr;
      rn[1] = rn[1] + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int d, input int base, input int conv, input int fc);
    if (d == 0) begin
      bus_a.i_src_base = AW'(base);
      bus_a.i_conv_len = LW'(conv);
      bus_a.i_fc_len   = LW'(fc);
    end else begin
      bus_b.i_src_base = AW'(base);
      bus_b.i_conv_len = LW'(conv);
      bus_b.i_fc_len   = LW'(fc);
    end
  endtask

  // Returns just after the start edge, i.e. in the first issue cycle.
  task automatic start(input int d, input int base, input int conv, input int fc);
    wn[d] = 0;
    rn[d] = 0;
    set_cfg(d, base, conv, fc);
    if (d == 0) bus_a.i_dma_start = 1'b1;
    else        bus_b.i_dma_start = 1'b1;
    tick();
    bus_a.i_dma_start = 1'b0;
    bus_b.i_dma_start = 1'b0;
  endtask

  task automatic check_xfer(input int d, input string tag, input int base, input int conv,
                            input int fc);
    int n;
    int idx;
    logic [AW-1:0] a;
    n = conv + NUM_FC * fc;
    chk($sformatf("%s wr count", tag), wn[d], n);
    chk($sformatf("%s rd count", tag), rn[d], n);
    idx = 0;
    for (int s = 0; s <= NUM_FC; s++) begin
      for (int j = 0; j < ((s == 0) ? conv : fc); j++) begin
        a = AW'(base + idx);
        if (idx < wn[d] && idx < rn[d] && idx < 64) begin
          chk($sformatf("%s rd addr %0d", tag, idx), raddr[d][idx], a);
          chk($sformatf("%s wr bank %0d", tag, idx), wbank[d][idx], 32'(1) << s);
          chk($sformatf("%s wr addr %0d", tag, idx), waddr[d][idx], j);
          chk($sformatf("%s wr data %0d", tag, idx), wdata[d][idx], a);
        end
        idx++;
      end
    end
  endtask

`ifdef WDMA_CHECKSUM_EN
  task automatic check_csum(input string tag, input logic [DW-1:0] obs, input int base,
                            input int n);
    logic [DW-1:0] sum;
    sum = '0;
    for (int i = 0; i < n; i++) sum = sum + DW'(base + i);
    chk(tag, obs, sum);
  endtask
`endif

  initial begin
    wn[0] = 0; wn[1] = 0; rn[0] = 0; rn[1] = 0;
    bus_a.i_dma_start = 1'b0; bus_a.i_abort = 1'b0;
    bus_b.i_dma_start = 1'b0; bus_b.i_abort = 1'b0;
    set_cfg(0, 0, 0, 0);
    set_cfg(1, 0, 0, 0);
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (2) tick();

    chk("rst src_rd",   bus_a.o_src_rd, 0);
    chk("rst src_addr", bus_a.o_src_addr, 0);
    chk("rst wr_en",    bus_a.o_wr_en, 0);
    chk("rst wr_bank",  bus_a.o_wr_bank, 0);
    chk("rst wr_addr",  bus_a.o_wr_addr, 0);
    chk("rst busy",     bus_a.o_busy, 0);
    chk("rst done",     bus_a.o_done, 0);

    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    tick();

    // T1: 3 conv words + 4 FC banks x 2 words, done 12 edges after the start edge
    start(0, 16'h0010, 3, 2);
    chk("T1 busy",      bus_a.o_busy, 1);
    chk("T1 src_rd",    bus_a.o_src_rd, 1);
    chk("T1 src_addr",  bus_a.o_src_addr, 16'h0010);
    chk("T1 done low",  bus_a.o_done, 0);
    repeat (11) tick();
    chk("T1 done early",   bus_a.o_done, 0);
    chk("T1 busy at end",  bus_a.o_busy, 1);
    chk("T1 last wr_en",   bus_a.o_wr_en, 1);
    chk("T1 last wr_bank", bus_a.o_wr_bank, 5'b10000);
    chk("T1 last wr_addr", bus_a.o_wr_addr, 1);
    tick();
    chk("T1 done",     bus_a.o_done, 1);
    chk("T1 idle",     bus_a.o_busy, 0);
    chk("T1 wr off",   bus_a.o_wr_en, 0);
    check_xfer(0, "T1", 16'h0010, 3, 2);
`ifdef WDMA_CHECKSUM_EN
    check_csum("T1 checksum", bus_a.o_checksum, 16'h0010, 11);
`endif

    // T2: empty conv segment is skipped
    start(0, 16'h0020, 0, 1);
    chk("T2 done cleared", bus_a.o_done, 0);
    repeat (5) tick();
    chk("T2 done", bus_a.o_done, 1);
    check_xfer(0, "T2", 16'h0020, 0, 1);

    // T3: source address wraps at 2^AW
    start(0, 16'hFFFE, 4, 0);
    repeat (5) tick();
    chk("T3 done", bus_a.o_done, 1);
    check_xfer(0, "T3", 16'hFFFE, 4, 0);

    // Both lengths zero: done on the next cycle without any read
    start(0, 16'h0030, 0, 0);
    chk("Z done",   bus_a.o_done, 1);
    chk("Z busy",   bus_a.o_busy, 0);
    chk("Z src_rd", bus_a.o_src_rd, 0);
    repeat (3) tick();
    chk("Z wr count", wn[0], 0);
    chk("Z rd count", rn[0], 0);

    // Start together with abort in IDLE is refused
    wn[0] = 0; rn[0] = 0;
    set_cfg(0, 16'h0040, 2, 2);
    bus_a.i_dma_start = 1'b1;
    bus_a.i_abort = 1'b1;
    tick();
    bus_a.i_dma_start = 1'b0;
    bus_a.i_abort = 1'b0;
    chk("SA busy",   bus_a.o_busy, 0);
    chk("SA src_rd", bus_a.o_src_rd, 0);
    repeat (3) tick();
    chk("SA rd count", rn[0], 0);
    chk("SA wr count", wn[0], 0);

    // T4: abort during the third issue cycle
    start(0, 16'h0010, 3, 2);
    repeat (2) tick();
    bus_a.i_abort = 1'b1;
    tick();
    bus_a.i_abort = 1'b0;
    chk("T4 src_rd", bus_a.o_src_rd, 0);
    chk("T4 wr_en",  bus_a.o_wr_en, 0);
    chk("T4 busy",   bus_a.o_busy, 0);
    chk("T4 done",   bus_a.o_done, 0);
    repeat (3) tick();
    chk("T4 wr count", wn[0], 2);
    chk("T4 rd count", rn[0], 3);

    // Restart completes; a start pulse while busy is ignored
    start(0, 16'h0010, 3, 2);
    repeat (4) tick();
    set_cfg(0, 16'h0200, 1, 1);
    bus_a.i_dma_start = 1'b1;
    tick();
    bus_a.i_dma_start = 1'b0;
    repeat (7) tick();
    chk("T4r done", bus_a.o_done, 1);
    check_xfer(0, "T4r", 16'h0010, 3, 2);
`ifdef WDMA_CHECKSUM_EN
    check_csum("T4r checksum", bus_a.o_checksum, 16'h0010, 11);
`endif

    // T5: read latency 3, done 14 edges after the start edge
    start(1, 16'h0010, 3, 2);
    repeat (13) tick();
    chk("T5 done early", bus_b.o_done, 0);
    chk("T5 last wr_en", bus_b.o_wr_en, 1);
    tick();
    chk("T5 done", bus_b.o_done, 1);
    chk("T5 idle", bus_b.o_busy, 0);
    check_xfer(1, "T5", 16'h0010, 3, 2);
`ifdef WDMA_CHECKSUM_EN
    check_csum("T5 checksum", bus_b.o_checksum, 16'h0010, 11);
`endif

    // Asynchronous reset mid-ISSUE
    start(1, 16'h0010, 3, 2);
    repeat (3) tick();
    chk("T5r wr_en before", bus_b.o_wr_en, 1);
    #2 rst_b_n = 1'b0;
    #1;
    chk("T5r src_rd",   bus_b.o_src_rd, 0);
    chk("T5r src_addr", bus_b.o_src_addr, 0);
    chk("T5r wr_en",    bus_b.o_wr_en, 0);
    chk("T5r wr_bank",  bus_b.o_wr_bank, 0);
    chk("T5r wr_addr",  bus_b.o_wr_addr, 0);
    chk("T5r busy",     bus_b.o_busy, 0);
    chk("T5r done",     bus_b.o_done, 0);
    @(negedge clk);
    rst_b_n = 1'b1;
    repeat (2) tick();
    chk("T5r stays idle", bus_b.o_busy, 0);
    chk("T5r no reads",   bus_b.o_src_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
